// File: rtl/display_peripheral_if.sv
// display_peripheral_if: value input and eleven seven-segment digit outputs plus busy dot.
interface display_peripheral_if;
    logic [31:0] din;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8, hex9, hex10;
    logic        dot;
    modport master (
        output din,
        input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8, hex9, hex10, dot
    );
    modport slave (
        input  din,
        output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8, hex9, hex10, dot
    );
endinterface

// File: rtl/display_peripheral_core.sv
// display_peripheral_core: signed 32-bit value to ten decimal digits plus sign via serial double-dabble.
// Optional feature: DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zeros in hex9..hex1.
module display_peripheral_core #(
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input logic                 clk,
    input logic                 rst,
    display_peripheral_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] ZERO  = 7'b1000000;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    state_t      state, nxt;
    logic        valid, dot_q, lz;
    logic [31:0] val, cmt, sh, mag;
    logic [39:0] bcd, adj;
    logic [5:0]  cnt;
    logic [3:0]  d;
    logic [6:0]  seg_q [11];
    logic [6:0]  seg_n [11];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: glyph = 7'b1000000;
            4'd1: glyph = 7'b1111001;
            4'd2: glyph = 7'b0100100;
            4'd3: glyph = 7'b0110000;
            4'd4: glyph = 7'b0011001;
            4'd5: glyph = 7'b0010010;
            4'd6: glyph = 7'b0000010;
            4'd7: glyph = 7'b1111000;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0010000;
            default: glyph = BLANK;
        endcase
    endfunction

    function automatic logic [6:0] pol(input logic [6:0] g);
        return DIGIT_ACTIVE_LOW != 0 ? g : ~g;
    endfunction

    assign mag = val[31] ? ~val + 32'd1 : val;

    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = IDLE;
        nxt = state == IDLE    ? ((!valid || bus.din != cmt) ? CONVERT : IDLE) :
              state == CONVERT ? (cnt == 6'd32 ? COMMIT : CONVERT) : IDLE;
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 10; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // lz stays set while every digit from hex9 down to the current one is zero
    always_comb begin
        seg_n = '{default: BLANK};
        lz = 1'b1;
        d = '0;
        for (int i = 9; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            lz = lz && d == 4'd0;
            seg_n[i] = pol((LZB && lz && i != 0) ? BLANK : glyph(d));
        end
        seg_n[10] = pol(val[31] ? MINUS : BLANK);
    end

    // CONVERT spends cnt==0 loading the magnitude, then 32 shift cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            cnt <= '0;
            val <= '0;
            cmt <= '0;
            sh <= '0;
            bcd <= '0;
            dot_q <= DIGIT_ACTIVE_LOW != 0;
            for (int i = 0; i < 11; i++)
                seg_q[i] <= pol((i == 10 || (LZB && i != 0)) ? BLANK : ZERO);
        end else begin
            dot_q <= (nxt == IDLE) == (DIGIT_ACTIVE_LOW != 0);
            if (state == IDLE && nxt == CONVERT) begin
                val <= bus.din;
                cnt <= '0;
            end
            if (state == CONVERT) begin
                cnt <= cnt + 6'd1;
                if (cnt == 6'd0) begin
                    sh <= mag;
                    bcd <= '0;
                end else
                    {bcd, sh} <= {adj, sh} << 1;
            end
            if (state == COMMIT) begin
                seg_q <= seg_n;
                cmt <= val;
                valid <= 1'b1;
            end
        end
    end

    assign bus.hex0  = seg_q[0];
    assign bus.hex1  = seg_q[1];
    assign bus.hex2  = seg_q[2];
    assign bus.hex3  = seg_q[3];
    assign bus.hex4  = seg_q[4];
    assign bus.hex5  = seg_q[5];
    assign bus.hex6  = seg_q[6];
    assign bus.hex7  = seg_q[7];
    assign bus.hex8  = seg_q[8];
    assign bus.hex9  = seg_q[9];
    assign bus.hex10 = seg_q[10];
    assign bus.dot   = dot_q;
endmodule

// File: tb/tb_display_peripheral_core.sv
// tb_display_peripheral_core: scoreboard bench for active-low and active-high builds side by side.
module tb_display_peripheral_core;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] GL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [31:0] DIRS [8] = '{32'hFFFFFFFF, 32'h80000000, 32'd8, 32'd0, 32'h7FFFFFFF,
                                         32'd1000000000, 32'hC4653600, 32'd9};
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    typedef struct {
        logic [31:0] v;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [31:0] last, rv;
    bit lv = 1'b0;
    int unsigned sel;
    logic [10:0][6:0] out0, out1, prev;
    logic pdot = 1'b1;

    display_peripheral_if b0 ();
    display_peripheral_if b1 ();
    assign b1.din = b0.din;

    display_peripheral_core dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    display_peripheral_core #(.DIGIT_ACTIVE_LOW(0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    assign out0 = {b0.hex10, b0.hex9, b0.hex8, b0.hex7, b0.hex6, b0.hex5,
                   b0.hex4, b0.hex3, b0.hex2, b0.hex1, b0.hex0};
    assign out1 = {b1.hex10, b1.hex9, b1.hex8, b1.hex7, b1.hex6, b1.hex5,
                   b1.hex4, b1.hex3, b1.hex2, b1.hex1, b1.hex0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expected active-low display built from the decimal string of |v|
    function automatic logic [10:0][6:0] model(input logic [31:0] v);
        longint m;
        string s;
        int d;
        logic [10:0][6:0] r;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        s = $sformatf("%0d", m);
        for (int i = 0; i < 10; i++) begin
            d = i < s.len() ? int'(s[s.len() - 1 - i]) - 48 : 0;
            r[i] = (LZB && i >= s.len()) ? BLANK : GL[d];
        end
        r[10] = v[31] ? MINUS : BLANK;
        return r;
    endfunction

    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // called on a negedge while the DUT is idle; the next posedge samples din
    task automatic issue(input logic [31:0] v);
        b0.din = v;
        if (!lv || v != last) q.push_back('{v, cyc + 35});
        last = v;
        lv = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 150 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input logic [31:0] v);
        @(negedge clk);
        rst = 1'b1;
        b0.din = v;
        q.delete();
        lv = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_digits", out0, model(32'd0));
        chk("reset_digits_active_high", out1, ~model(32'd0));
        chk("reset_dot", {76'd0, b0.dot}, 77'd1);
        chk("reset_dot_active_high", {76'd0, b1.dot}, 77'd0);
        @(negedge clk);
        rst = 1'b0;
        q.push_back('{v, cyc + 35});
        last = v;
        lv = 1'b1;
    endtask

    // monitor: a dot transition from lit to unlit marks a commit
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (!pdot && b0.dot) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit actual=%h required=none", out0);
                    end else begin
                        e = q.pop_front();
                        chk("digits", out0, model(e.v));
                        chk("digits_active_high", out1, ~model(e.v));
                        chk("dot_active_high", {76'd0, b1.dot}, 77'd0);
                        chk("latency", 77'(cyc), 77'(e.due));
                    end
                end else
                    chk("stable", out0, prev);
            end
            prev = out0;
            pdot = b0.dot;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        b0.din = 32'h0;
        do_reset(32'h7FFFFFF0);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            issue(DIRS[i]);
            wait_done();
        end
        issue(last);
        repeat (5) @(negedge clk);
        chk("idle_hold_dot", {76'd0, b0.dot}, 77'd1);
        do_reset(32'd0);
        wait_done();
        issue(32'd5);
        repeat (10) @(negedge clk);
        b0.din = 32'd9;
        q.push_back('{32'd9, q[0].due + 35});
        last = 32'd9;
        chk("dot_lit_during_convert", {76'd0, b0.dot}, 77'd0);
        wait_done();
        issue(32'd12345);
        repeat (20) @(negedge clk);
        do_reset(32'd12345);
        wait_done();
        for (int k = 0; k < 20; k++) begin
            sel = $urandom_range(0, 4);
            rv = sel == 0 ? last : sel == 1 ? 32'($urandom_range(0, 999)) :
                 sel == 2 ? -32'($urandom_range(1, 999)) : $urandom;
            issue(rv);
            wait_done();
        end
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_peripheral_core.md
DISPLAY_PERIPHERAL_CORE -- requirements
Module: display_peripheral

Interface
REQ-001 Parameter DIGIT_ACTIVE_LOW, default 1: when 1, segment and dot outputs are active-low; when 0, all 78 output bits are inverted (active-high).
REQ-002 clk  input  1  single clock for all logic; rising-edge triggered.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  32  signed two's-complement value to display.
REQ-005 hex0..hex9  output  7 each  decimal digits; hex0 is least significant. Bit0=seg a through bit6=seg g.
REQ-006 hex10  output  7  sign digit.
REQ-007 dot  output  1  busy indicator.

Function
REQ-008 Glyph encoding (active-low, bits g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
REQ-009 The block displays din as signed decimal: magnitude on hex9..hex0, minus glyph on hex10 when din<0, blank hex10 when din>=0.
REQ-010 The magnitude is |din| computed as a 32-bit unsigned value; din=0x80000000 displays -2147483648 with no overflow.
REQ-011 FSM states: IDLE, CONVERT, COMMIT.
REQ-012 IDLE: on each edge, sample din; if it differs from the last committed value, or no value has been committed since reset, latch it and enter CONVERT.
REQ-013 CONVERT: serial double-dabble, exactly 32 shift cycles into a 40-bit BCD register (add 3 to any BCD nibble >=5 before each shift), then enter COMMIT.
REQ-014 COMMIT: register all eleven digit outputs and the committed value in one cycle, then return to IDLE.
REQ-015 Latency: outputs update at the 34th rising edge after the sampling edge; all digits change on the same edge (no partial updates).
REQ-016 Changes of din during CONVERT/COMMIT are ignored; din is resampled on the first IDLE cycle.
REQ-017 dot is driven lit (0) in CONVERT and COMMIT, and unlit (1) in IDLE.
REQ-018 All outputs are registered; no combinational path from din to any output.

Reset
REQ-019 When rst=1 at a clock edge: FSM goes to IDLE; hex0..hex9 show the 0 glyph (1000000), or hex0=0 and hex1..hex9 blank when leading-zero blanking is compiled in; hex10 is blank; dot=1; the committed-value-valid flag clears.
REQ-020 Reset asserted mid-conversion aborts the conversion; no partial result is committed.
REQ-021 After reset is released, the first IDLE cycle samples din and starts a conversion unconditionally.

Configuration
REQ-022 Macro DISPLAY_LEADING_ZERO_BLANK_EN: when defined, leading zero digits in hex9..hex1 are driven blank, and hex0 always shows a glyph (value 0 shows a single "0"); when undefined, all ten digits always show glyphs including leading zeros. The sign digit is unaffected.

Verification
REQ-023 Reset, then din=0x7FFFFFF0 held -> after 34 edges: hex9..hex0 = 2,1,4,7,4,8,3,6,3,2; hex10 blank; dot=1.
REQ-024 din=0xFFFFFFFF -> hex10=minus and hex0=1; hex9..hex1 = 0 glyph, or blank with DISPLAY_LEADING_ZERO_BLANK_EN.
REQ-025 din=0x80000000 -> hex10=minus and hex9..hex0 = 2,1,4,7,4,8,3,6,4,8.
REQ-026 din changes 5 -> 9 at cycle 10 of a conversion -> display shows 5 first, then shows 9 exactly 34 edges after the next IDLE sample; dot stays 0 throughout both conversions except for the IDLE cycle between them.
REQ-027 rst asserted at cycle 20 of a conversion of 12345 -> outputs return to reset values on that edge; after release, 12345 is displayed 34 edges after the first IDLE sample.
REQ-028 Build with DIGIT_ACTIVE_LOW=0 and din=8 -> hex0=1111111, blank digits=0000000, and dot=0 in IDLE.
